ps2_kbd_emu: RTL
================

Name: ps2_kbd_emu

Overview:
- Synthesizable PS/2 keyboard (device-side) emulator.
- Accepts key events over a valid/ready interface and buffers them in a FIFO.
- Expands each event into the scancode byte sequence: optional E0 prefix, optional F0 break prefix, then the code.
- Serialises each byte as an 11-bit PS/2 frame on ps2_clk/ps2_data with programmable timing.
- Drives ctrl_main_block-class designs in hardware loopback and in bench, replacing hand-written stimulus tasks.

Parameters:
- HALF_PER, 750: clk cycles per ps2_clk half-period (low or high).
- GAP_CYC, 10000: idle clk cycles after each byte's stop bit before the next byte may start.
- FIFO_DEPTH, 4: event FIFO entries; must be a power of 2, at least 2.
- CW, 16: width of the timing counter; must hold max(HALF_PER, GAP_CYC).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous active-low reset.
- key_valid  in  1  event offered.
- key_ready  out  1  FIFO can accept an event.
- key_code  in  8  scancode.
- key_ext  in  1  prefix E0.
- key_break  in  1  prefix F0 (release).
- host_inhibit  in  1  host holding the PS/2 clock low (synchronised internally, 2 flops).
- ps2_clk  out  1  PS/2 clock, idle 1.
- ps2_data  out  1  PS/2 data, idle 1.
- busy  out  1  frame or gap in progress, or FIFO not empty.
- fifo_cnt  out  $clog2(FIFO_DEPTH)+1  occupied entries.
- bytes_sent  out  16  completed frames, wraps 0xFFFF→0.

Behaviour:
- Reset values: ps2_clk=1, ps2_data=1, key_ready=1, busy=0, fifo_cnt=0, bytes_sent=0, FSM=IDLE.
- Reset mid-frame aborts the frame; both lines return high asynchronously and the FIFO is flushed.
- Push: key_valid && key_ready at a rising clk edge stores {ext,brk,code}. key_ready = (fifo_cnt != FIFO_DEPTH).
- Pop and push in the same cycle are both legal when the FIFO is full; fifo_cnt is then unchanged.
- FSM states: IDLE, LOAD, HI, LO, GAP, WAIT_INH.
  - IDLE: if FIFO not empty and inhibit is low → LOAD next cycle.
  - LOAD: pop the entry and build byte list [E0 if ext][F0 if brk][code] (1–3 bytes). Select the first byte and form frame {1, ~^byte, byte[7:0], 0}, LSB sent first. Set bit_idx=0 and drive ps2_data=start bit → HI.
  - HI: ps2_clk=1 and ps2_data=frame[bit_idx], held HALF_PER cycles → LO.
  - LO: ps2_clk=0, held HALF_PER cycles. Then ps2_clk=1, bit_idx++. If bit_idx==11 → GAP, else → HI with the data updated on the same edge.
  - GAP: bytes_sent++ on entry; lines high for GAP_CYC cycles. Then: next byte of the list → HI (new frame); list done and FIFO not empty → LOAD; otherwise → IDLE.
  - WAIT_INH: entered from HI/LO/GAP when synchronised host_inhibit=1. Lines go high and the current byte's frame is discarded. When inhibit clears, wait GAP_CYC cycles, then restart the same byte from the start bit. The remaining list bytes are kept.
- Timing: first ps2_data fall occurs 2 cycles after the accepting edge when idle. One frame lasts 22·HALF_PER cycles. A byte-to-byte period is 22·HALF_PER+GAP_CYC.
- Data changes only while ps2_clk is high, at least HALF_PER cycles before the falling edge.
- busy = (state!=IDLE) || fifo_cnt!=0.

Optional Feature:
- Macro PS2_KBD_AUTO_BREAK_EN.
- Defined: every popped make event (key_break=0) is followed, after its last byte's GAP, by an automatic break sequence [E0 if ext] F0 code, without a FIFO entry. Break events pushed explicitly are sent unchanged.
- Undefined: only the events pushed are sent.

Decomposition:
- Package ps2_pkg holds:
  - Constants PS2_EXT=8'hE0 and PS2_BRK=8'hF0.
  - Frame length constant PS2_FRAME_BITS=11.
  - FSM enum ps2_tx_st_t.
  - Struct ps2_evt_t {ext, brk, code}.
- Sub-module ps2_evt_fifo (parametrised sync FIFO of ps2_evt_t); the serializer FSM stays in the top module.

Test Plan (HALF_PER=4, GAP_CYC=20, FIFO_DEPTH=4):
- Push code 0x1D, ext=0, brk=0 → one frame, sampled on ps2_clk falls: 0,1,0,1,1,1,0,0,0, parity 1, stop 1. bytes_sent=1, busy falls 20 cycles after the stop bit.
- Push 0x29 with brk=1 → frames F0 (parity 1) then 29 (parity 0), 108 cycles apart from start bit to start bit. bytes_sent=2.
- Push 0x75 with ext=1, brk=1 → E0, F0, 75 in order. With PS2_KBD_AUTO_BREAK_EN and a make of 0x75 ext → E0,75,E0,F0,75.
- Hold the serializer with inhibit and push 5 events → key_ready=0 after the 4th and fifo_cnt=4; the 5th is held and accepted once the first pop occurs.
- Assert host_inhibit during data bit 3 of 0x1D → lines go high. After release plus 20 cycles the full 0x1D frame is resent, and bytes_sent increments once.
- Assert reset low mid-frame → ps2_clk=ps2_data=1 immediately, fifo_cnt=0, bytes_sent=0. After release the block stays idle with no frame sent.

Source files
------------

// File: rtl/ps2_pkg.sv
// ps2_pkg -- shared types and constants for the PS/2 keyboard emulator.
//   PS2_EXT / PS2_BRK : scancode prefix bytes (E0 extended, F0 break)
//   PS2_FRAME_BITS    : start + 8 data + parity + stop
//   ps2_tx_st_t       : serializer FSM states
//   ps2_evt_t         : one queued key event {ext, brk, code}
//   ps2_list_t        : expanded byte list of one event (1..3 bytes)
//   ps2_frame()       : byte -> 11-bit frame, LSB transmitted first
//   ps2_build_list()  : event -> byte list
package ps2_pkg;

  localparam logic [7:0]  PS2_EXT        = 8'hE0;
  localparam logic [7:0]  PS2_BRK        = 8'hF0;
  localparam int unsigned PS2_FRAME_BITS = 11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_HI,
    ST_LO,
    ST_GAP,
    ST_WAIT_INH
  } ps2_tx_st_t;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_evt_t;

  typedef struct packed {
    logic [2:0][7:0] b;
    logic [1:0]      len;
  } ps2_list_t;

  // Odd parity: parity bit makes the count of ones over data+parity odd.
  function automatic logic [PS2_FRAME_BITS-1:0] ps2_frame(input logic [7:0] data);
    return {1'b1, ~^data, data, 1'b0};
  endfunction

  function automatic ps2_list_t ps2_build_list(input ps2_evt_t e);
    ps2_list_t l;
    l = '0;
    case ({e.ext, e.brk})
      2'b00: begin
        l.b[0] = e.code;
        l.len  = 2'd1;
      end
      2'b10: begin
        l.b[0] = PS2_EXT;
        l.b[1] = e.code;
        l.len  = 2'd2;
      end
      2'b01: begin
        l.b[0] = PS2_BRK;
        l.b[1] = e.code;
        l.len  = 2'd2;
      end
      default: begin
        l.b[0] = PS2_EXT;
        l.b[1] = PS2_BRK;
        l.b[2] = e.code;
        l.len  = 2'd3;
      end
    endcase
    return l;
  endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// ps2_evt_fifo -- synchronous FIFO of ps2_evt_t entries.
//   clk_i, rst_ni : clock, asynchronous active-low reset (flushes pointers)
//   push_i/wdata_i: write an entry (accepted when not full, or full with pop)
//   pop_i/rdata_o : rdata_o shows the head entry; pop_i removes it
//   cnt_o         : occupied entries, 0..DEPTH
module ps2_evt_fifo
  import ps2_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  ps2_evt_t               wdata_i,
  input  logic                   pop_i,
  output ps2_evt_t               rdata_o,
  output logic [$clog2(DEPTH):0] cnt_o
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam logic [AW:0] FULL    = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_C   = (AW+1)'(1);
  localparam logic [AW-1:0] ONE_P = AW'(1);

  ps2_evt_t      mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          full, empty, do_push, do_pop;

  assign full    = (cnt_q == FULL);
  assign empty   = (cnt_q == '0);
  assign do_push = push_i && (!full || pop_i);
  assign do_pop  = pop_i && !empty;
  assign rdata_o = mem_q[rd_ptr_q];
  assign cnt_o   = cnt_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = wr_ptr_q + ONE_P;
    if (do_pop)  rd_ptr_d = rd_ptr_q + ONE_P;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + ONE_C;
      2'b01:   cnt_d = cnt_q - ONE_C;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/ps2_kbd_emu.sv
// ps2_kbd_emu -- device-side PS/2 keyboard emulator.
// Key events are queued in a FIFO, expanded into [E0][F0]code bytes and
// sent as 11-bit PS/2 frames (start, 8 data LSB first, odd parity, stop).
//   clk, reset (async, active-low)
//   key_valid/key_ready/key_code/key_ext/key_break : event input handshake
//   host_inhibit : host holding the clock low (2-flop synchronised)
//   ps2_clk/ps2_data : PS/2 lines, idle high
//   busy, fifo_cnt, bytes_sent : status
// Build option: define PS2_KBD_AUTO_BREAK_EN to follow every make event with
// its break sequence automatically.
module ps2_kbd_emu
  import ps2_pkg::*;
#(
  parameter int unsigned HALF_PER   = 750,
  parameter int unsigned GAP_CYC    = 10000,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CW         = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        key_valid,
  output logic                        key_ready,
  input  logic [7:0]                  key_code,
  input  logic                        key_ext,
  input  logic                        key_break,
  input  logic                        host_inhibit,
  output logic                        ps2_clk,
  output logic                        ps2_data,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_cnt,
  output logic [15:0]                 bytes_sent
);

  localparam int unsigned      AW        = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]      FULL_CNT  = (AW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0]    HALF_LAST = CW'(HALF_PER - 1);
  localparam logic [CW-1:0]    GAP_LAST  = CW'(GAP_CYC - 1);
  localparam logic [CW-1:0]    CNT_ONE   = CW'(1);
  localparam logic [3:0]       LAST_BIT  = 4'(PS2_FRAME_BITS - 1);

  ps2_tx_st_t                  state_q, state_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic [3:0]                  bit_idx_q, bit_idx_d;
  logic [PS2_FRAME_BITS-1:0]   frame_q, frame_d;
  ps2_list_t                   lst_q, lst_d;
  logic [1:0]                  idx_q, idx_d;
  ps2_evt_t                    evt_q, evt_d;
  logic                        auto_q, auto_d;
  logic                        resend_q, resend_d;
  logic                        ps2_clk_q, ps2_clk_d;
  logic                        ps2_data_q, ps2_data_d;
  logic [15:0]                 sent_q, sent_d;
  logic                        inh_s1_q, inh_s2_q;

  logic                        push, pop, advance, start;
  logic [1:0]                  nidx;
  ps2_evt_t                    push_evt, fifo_rd, brk_evt;
  logic                        fifo_nempty;

  assign key_ready   = (fifo_cnt != FULL_CNT);
  assign push        = key_valid && key_ready;
  assign push_evt    = '{ext: key_ext, brk: key_break, code: key_code};
  assign fifo_nempty = (fifo_cnt != '0);

  ps2_evt_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (clk),
    .rst_ni (reset),
    .push_i (push),
    .wdata_i(push_evt),
    .pop_i  (pop),
    .rdata_o(fifo_rd),
    .cnt_o  (fifo_cnt)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inh_s1_q <= 1'b0;
      inh_s2_q <= 1'b0;
    end else begin
      inh_s1_q <= host_inhibit;
      inh_s2_q <= inh_s1_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    frame_d    = frame_q;
    lst_d      = lst_q;
    idx_d      = idx_q;
    evt_d      = evt_q;
    auto_d     = auto_q;
    resend_d   = resend_q;
    ps2_clk_d  = ps2_clk_q;
    ps2_data_d = ps2_data_q;
    sent_d     = sent_q;
    pop        = 1'b0;
    advance    = 1'b0;
    start      = 1'b0;
    nidx       = idx_q + 2'd1;
    brk_evt    = evt_q;
    brk_evt.brk = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (fifo_nempty && !inh_s2_q) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        pop     = 1'b1;
        evt_d   = fifo_rd;
        lst_d   = ps2_build_list(fifo_rd);
        idx_d   = 2'd0;
        frame_d = ps2_frame(lst_d.b[0]);
        start   = 1'b1;
`ifdef PS2_KBD_AUTO_BREAK_EN
        auto_d  = !fifo_rd.brk;
`else
        auto_d  = 1'b0;
`endif
      end
      ST_HI, ST_LO: begin
        if (inh_s2_q) begin
          // Abort the frame; frame_q/idx_q are kept so the byte is resent.
          state_d    = ST_WAIT_INH;
          resend_d   = 1'b1;
          cnt_d      = '0;
          ps2_clk_d  = 1'b1;
          ps2_data_d = 1'b1;
        end else if (cnt_q != HALF_LAST) begin
          cnt_d = cnt_q + CNT_ONE;
        end else if (state_q == ST_HI) begin
          cnt_d     = '0;
          ps2_clk_d = 1'b0;
          state_d   = ST_LO;
        end else begin
          cnt_d     = '0;
          ps2_clk_d = 1'b1;
          bit_idx_d = bit_idx_q + 4'd1;
          if (bit_idx_q == LAST_BIT) begin
            state_d    = ST_GAP;
            ps2_data_d = 1'b1;
            sent_d     = sent_q + 16'd1;
          end else begin
            state_d    = ST_HI;
            ps2_data_d = frame_q[bit_idx_d];
          end
        end
      end
      ST_GAP: begin
        if (inh_s2_q) begin
          // Byte already delivered: after the inhibit, continue with the next one.
          state_d  = ST_WAIT_INH;
          resend_d = 1'b0;
          cnt_d    = '0;
        end else if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          advance = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_WAIT_INH: begin
        ps2_clk_d  = 1'b1;
        ps2_data_d = 1'b1;
        if (inh_s2_q) begin
          cnt_d = '0;
        end else if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          if (resend_q) begin
            resend_d = 1'b0;
            start    = 1'b1;
          end else begin
            advance = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (advance) begin
      if (nidx < lst_q.len) begin
        idx_d   = nidx;
        frame_d = ps2_frame(lst_q.b[nidx]);
        start   = 1'b1;
      end else if (auto_q) begin
        auto_d  = 1'b0;
        lst_d   = ps2_build_list(brk_evt);
        idx_d   = 2'd0;
        frame_d = ps2_frame(lst_d.b[0]);
        start   = 1'b1;
      end else if (fifo_nempty) begin
        state_d = ST_LOAD;
      end else begin
        state_d = ST_IDLE;
      end
    end

    if (start) begin
      state_d    = ST_HI;
      bit_idx_d  = 4'd0;
      cnt_d      = '0;
      ps2_clk_d  = 1'b1;
      ps2_data_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      frame_q    <= '1;
      lst_q      <= '0;
      idx_q      <= '0;
      evt_q      <= '0;
      auto_q     <= 1'b0;
      resend_q   <= 1'b0;
      ps2_clk_q  <= 1'b1;
      ps2_data_q <= 1'b1;
      sent_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      frame_q    <= frame_d;
      lst_q      <= lst_d;
      idx_q      <= idx_d;
      evt_q      <= evt_d;
      auto_q     <= auto_d;
      resend_q   <= resend_d;
      ps2_clk_q  <= ps2_clk_d;
      ps2_data_q <= ps2_data_d;
      sent_q     <= sent_d;
    end
  end

  assign ps2_clk    = ps2_clk_q;
  assign ps2_data   = ps2_data_q;
  assign bytes_sent = sent_q;
  assign busy       = (state_q != ST_IDLE) || fifo_nempty;

endmodule
